// File: rtl/bloom_pkg.sv
// -----------------------------------------------------------------------------
// bloom_pkg
//   Shared types and sizing helpers for the Bloom filter query controller.
//   - bq_state_t    : sequencer state encoding
//   - bq_cnt_width  : width of the hash index counter for a given hash count
//   - BQ_CNT_W      : counter width for the default configuration (12 hashes)
// -----------------------------------------------------------------------------
package bloom_pkg;

  typedef enum logic [2:0] {
    BQ_IDLE   = 3'd0,
    BQ_INSERT = 3'd1,
    BQ_LOOKUP = 3'd2,
    BQ_DRAIN  = 3'd3,
    BQ_CLEAR  = 3'd4,
    BQ_RESULT = 3'd5
  } bq_state_t;

  localparam int BQ_HASHES_CNT_DEF = 12;

  // The index counter has to reach HASHES_CNT itself ("all issued"), hence +1.
  localparam int BQ_CNT_W = $clog2(BQ_HASHES_CNT_DEF + 1);

  function automatic int bq_cnt_width(input int hashes_cnt);
    return $clog2(hashes_cnt + 1);
  endfunction

endpackage

// File: rtl/bloom_query_ctrl.sv
// -----------------------------------------------------------------------------
// bloom_query_ctrl
//   Sequencer between the hasher output stream and a single-port Bloom bit RAM.
//   Each accepted string either sets HASHES_CNT bits (insert) or tests them
//   (lookup, stopping at the first zero bit). A latched clear request sweeps
//   the whole RAM to zero. One result per accepted string, in order, with the
//   string attached.
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   hashes_i       hash set, hash k at [k*HASH_W +: HASH_W]
//   data_i         string travelling with the hashes
//   insert_i       1 = insert, 0 = lookup (sampled on accept)
//   valid_i        request valid
//   ready_o        request accepted when valid_i & ready_o
//   clear_i        single-cycle clear request, latched
//   busy_o         high in every state except IDLE
//   mem_addr_o     bit-RAM address
//   mem_rd_o       read strobe, mem_rdata_i valid one cycle later
//   mem_wr_o       write strobe
//   mem_wdata_o    write bit (1 insert, 0 clear)
//   mem_rdata_i    read data
//   match_o        lookup hit (always 0 for inserts)
//   is_insert_o    result belongs to an insert
//   data_o         string of this result
//   res_valid_o    result valid
//   res_ready_i    result consumer ready
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a request or a pending clear (clear wins)
// INSERT | one write of 1 per hash
// LOOKUP | one read per hash, aborts on the first zero seen
// DRAIN  | no strobe; checks the read data of the final hash
// CLEAR  | writes 0 to every RAM address, 0 .. 2**HASH_W-1
// RESULT | result held on the outputs until res_ready_i
// -----------------------------------------------------------------------------
import bloom_pkg::*;

module bloom_query_ctrl #(
  parameter int BYTE_W     = 8,
  parameter int STR_SIZE   = 6,
  parameter int HASHES_CNT = 12,
  parameter int HASH_W     = 13
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [HASHES_CNT*HASH_W-1:0] hashes_i,
  input  logic [STR_SIZE*BYTE_W-1:0]   data_i,
  input  logic                         insert_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         clear_i,
  output logic                         busy_o,
  output logic [HASH_W-1:0]            mem_addr_o,
  output logic                         mem_rd_o,
  output logic                         mem_wr_o,
  output logic                         mem_wdata_o,
  input  logic                         mem_rdata_i,
  output logic                         match_o,
  output logic                         is_insert_o,
  output logic [STR_SIZE*BYTE_W-1:0]   data_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i
);

  localparam int CNT_W = bq_cnt_width(HASHES_CNT);
  localparam int HS_W  = HASHES_CNT * HASH_W;
  localparam int STR_W = STR_SIZE * BYTE_W;

  bq_state_t            state_q;
  logic [HS_W-1:0]      hash_sr_q;    // remaining hashes, next one in the low bits
  logic [CNT_W-1:0]     k_q;          // number of hashes already issued
  logic [HASH_W:0]      clr_cnt_q;    // one extra bit so the top address is reached
  logic [STR_W-1:0]     str_q;
  logic                 insert_q;
  logic                 clr_q;        // clear request latch
  logic                 rd_prev_q;    // a read was issued last cycle, data is on mem_rdata_i

  logic                 ready_q;
  logic                 busy_q;
  logic [HASH_W-1:0]    addr_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 wdata_q;
  logic                 match_q;
  logic                 is_insert_q;
  logic [STR_W-1:0]     data_q;
  logic                 res_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= BQ_IDLE;
      hash_sr_q   <= '0;
      k_q         <= '0;
      clr_cnt_q   <= '0;
      str_q       <= '0;
      insert_q    <= 1'b0;
      clr_q       <= 1'b0;
      rd_prev_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 1'b0;
      match_q     <= 1'b0;
      is_insert_q <= 1'b0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
    end else begin
      rd_prev_q <= rd_q;
      if (clear_i) begin
        clr_q <= 1'b1;
      end

      case (state_q)
        BQ_IDLE: begin
          if (clr_q) begin
            state_q   <= BQ_CLEAR;
            // A request arriving in the entry cycle must still be remembered.
            clr_q     <= clear_i;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            wr_q      <= 1'b1;
            wdata_q   <= 1'b0;
            addr_q    <= '0;
            clr_cnt_q <= (HASH_W+1)'(1);
          end else if (valid_i && ready_q) begin
            str_q     <= data_i;
            insert_q  <= insert_i;
            addr_q    <= hashes_i[HASH_W-1:0];
            hash_sr_q <= hashes_i >> HASH_W;
            k_q       <= CNT_W'(1);
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            if (insert_i) begin
              state_q <= BQ_INSERT;
              wr_q    <= 1'b1;
              wdata_q <= 1'b1;
            end else begin
              state_q <= BQ_LOOKUP;
              rd_q    <= 1'b1;
            end
          end else begin
            ready_q <= ~clear_i;
          end
        end

        BQ_INSERT: begin
          if (k_q == CNT_W'(HASHES_CNT)) begin
            state_q     <= BQ_RESULT;
            wr_q        <= 1'b0;
            res_valid_q <= 1'b1;
            match_q     <= 1'b0;
            is_insert_q <= 1'b1;
            data_q      <= str_q;
          end else begin
            addr_q    <= hash_sr_q[HASH_W-1:0];
            hash_sr_q <= hash_sr_q >> HASH_W;
            k_q       <= k_q + CNT_W'(1);
          end
        end

        BQ_LOOKUP: begin
          // An early zero ends the lookup; the read already on the bus is left alone.
          if (rd_prev_q && !mem_rdata_i) begin
            state_q     <= BQ_RESULT;
            rd_q        <= 1'b0;
            res_valid_q <= 1'b1;
            match_q     <= 1'b0;
            is_insert_q <= 1'b0;
            data_q      <= str_q;
          end else if (k_q == CNT_W'(HASHES_CNT)) begin
            state_q <= BQ_DRAIN;
            rd_q    <= 1'b0;
          end else begin
            addr_q    <= hash_sr_q[HASH_W-1:0];
            hash_sr_q <= hash_sr_q >> HASH_W;
            k_q       <= k_q + CNT_W'(1);
          end
        end

        BQ_DRAIN: begin
          // Every earlier bit was 1, so the final bit alone decides the match.
          state_q     <= BQ_RESULT;
          res_valid_q <= 1'b1;
          match_q     <= mem_rdata_i;
          is_insert_q <= 1'b0;
          data_q      <= str_q;
        end

        BQ_RESULT: begin
          if (res_ready_i) begin
            state_q     <= BQ_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= ~(clr_q | clear_i);
          end
        end

        BQ_CLEAR: begin
          if (clr_cnt_q[HASH_W]) begin
            state_q <= BQ_IDLE;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= ~(clr_q | clear_i);
          end else begin
            addr_q    <= clr_cnt_q[HASH_W-1:0];
            clr_cnt_q <= clr_cnt_q + (HASH_W+1)'(1);
          end
        end

        default: begin
          state_q <= BQ_IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = rd_q;
  assign mem_wr_o    = wr_q;
  assign mem_wdata_o = wdata_q;
  assign match_o     = match_q;
  assign is_insert_o = is_insert_q;
  assign data_o      = data_q;
  assign res_valid_o = res_valid_q;

endmodule
